// File: rtl/cla_seq_pkg.sv
// Shared types and sizing helpers for the nibble-serial CLA sequencer.
package cla_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Number of nibble passes needed for an operand of the given width.
  function automatic int unsigned nib_count(input int unsigned width);
    return width / NIBBLE_W;
  endfunction

  // Width of the nibble index counter for the given operand width.
  function automatic int unsigned idx_width(input int unsigned width);
    return (nib_count(width) > 1) ? $clog2(nib_count(width)) : 1;
  endfunction

endpackage

// File: rtl/cla_nibble_slice.sv
// Combinational 4-bit carry-lookahead slice; also exposes the carry into bit 3
// so the controller can form signed overflow on the final pass.
module cla_nibble_slice
  import cla_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum_c,
  output logic                cout_c,
  output logic                c3_c
);

  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W:0]   c;

  // Propagate/generate terms and flattened lookahead carries.
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
  end

  assign sum_c  = p ^ c[NIBBLE_W-1:0];
  assign cout_c = c[4];
  assign c3_c   = c[3];

endmodule

// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder: one shared CLA nibble slice, LSB nibble first,
// carry passed between passes through a register. Optional subtract mode is
// enabled by defining CLA_SEQ_SUB_EN (adds the op_sub port).
module cla_nibble_sequencer
  import cla_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             op_sub,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NIB   = nib_count(WIDTH);
  localparam int unsigned IDX_W = idx_width(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d, ovf_d;
  logic             res_valid_d, start_ready_d, busy_d;

  logic [NIBBLE_W-1:0] a_nib, b_nib, slice_sum;
  logic                slice_co, slice_c3;
  logic [WIDTH-1:0]    nib_mask;

  // Select the active nibble of each latched operand.
  assign a_nib    = NIBBLE_W'(a_q >> (NIBBLE_W * idx_q));
  assign b_nib    = NIBBLE_W'(b_q >> (NIBBLE_W * idx_q));
  assign nib_mask = WIDTH'({NIBBLE_W{1'b1}}) << (NIBBLE_W * idx_q);

  cla_nibble_slice u_slice (
    .a      (a_nib),
    .b      (b_nib),
    .cin    (carry_q),
    .sum_c  (slice_sum),
    .cout_c (slice_co),
    .c3_c   (slice_c3)
  );

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum;
    cout_d  = cout;
    ovf_d   = ovf;

    case (state_q)
      IDLE: begin
        if (start_valid && start_ready) begin
          a_d     = a;
`ifdef CLA_SEQ_SUB_EN
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub ? 1'b1 : cin;
`else
          b_d     = b;
          carry_d = cin;
`endif
          sum_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = (sum & ~nib_mask) | (WIDTH'(slice_sum) << (NIBBLE_W * idx_q));
        carry_d = slice_co;
        if (idx_q == IDX_LAST) begin
          cout_d  = slice_co;
          ovf_d   = slice_c3 ^ slice_co;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (res_valid && res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    res_valid_d   = (state_d == DONE);
    start_ready_d = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum         <= '0;
      cout        <= 1'b0;
      ovf         <= 1'b0;
      res_valid   <= 1'b0;
      start_ready <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      sum         <= sum_d;
      cout        <= cout_d;
      ovf         <= ovf_d;
      res_valid   <= res_valid_d;
      start_ready <= start_ready_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: doc/cla_nibble_sequencer.md
Name: cla_nibble_sequencer

Overview:
Multi-cycle wide adder controller. It adds two WIDTH-bit operands by passing them through one shared 4-bit carry-lookahead slice, one nibble per clock, LSB nibble first. A registered carry is passed from each nibble to the next. Valid/ready handshakes on the operand side and the result side let it sit between a requesting datapath and a result consumer, trading latency for area.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
NIB (localparam), WIDTH/4, number of nibble passes per operation.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start_valid  in  1  requester presents operands
start_ready  out  1  high only in IDLE
a  in  WIDTH  operand A, sampled on accept
b  in  WIDTH  operand B, sampled on accept
cin  in  1  carry-in, sampled on accept
res_valid  out  1  result available
res_ready  in  1  consumer takes result
sum  out  WIDTH  registered result
cout  out  1  carry out of MSB
ovf  out  1  signed overflow
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (asynchronous, active-low), applied immediately whenever rst_n is low:
  - state = IDLE, idx = 0, carry register = 0.
  - sum = 0, cout = 0, ovf = 0, res_valid = 0, busy = 0.
  - start_ready = 1 once state is IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1.
  - Accept occurs on a clock edge where start_valid & start_ready are both high.
  - On accept: latch a, b and cin; clear sum; set idx = 0; go to RUN.
- RUN, each cycle:
  - Slice inputs: nibble idx of latched a and b, plus the carry register.
  - On the clock edge, write the slice sum into sum[4*idx+3:4*idx] and load the carry register with the slice carry-out.
  - If idx = NIB-1: load cout with the slice carry-out, load ovf = carry into bit 3 XOR carry out of bit 3, then go to DONE. Otherwise idx increments.
- Latency: res_valid rises exactly NIB edges after the accept edge (4 edges for WIDTH=16).
- DONE:
  - res_valid = 1; sum, cout and ovf are held stable.
  - On an edge with res_valid & res_ready, go to IDLE and clear res_valid.
  - start_ready is only asserted back in IDLE, so the next accept is earliest on the edge after the handoff (no same-cycle bypass).
- Signal handling outside the active states:
  - start_valid is ignored in RUN and DONE.
  - res_ready is ignored in IDLE and RUN.
  - Operand inputs may change freely after accept.
- Carry chain: the carry ripples between nibbles only through the carry register. No combinational path exists from any input port to any output.
- Reset mid-operation: the operation is abandoned and no res_valid is produced for it.
- idx width: clog2(NIB); it never exceeds NIB-1.

Optional Feature:
CLA_SEQ_SUB_EN
- Defined:
  - Adds input port op_sub (1 bit), sampled on accept.
  - When op_sub = 1, the latched b is ~b and the initial carry is forced to 1; cin is ignored. The result is a - b.
  - cout = 1 means no borrow.
  - ovf uses the same MSB carry-in XOR carry-out rule.
- Undefined: the op_sub port is absent and the block is add-only.

Decomposition:
- Package cla_seq_pkg: state enum (IDLE, RUN, DONE), NIBBLE_W = 4, and a function returning NIB and the idx width for a given WIDTH.
- One sub-module, cla_nibble_slice: combinational 4-bit lookahead.
  - Inputs: p/g generation from the a/b nibbles, plus carry-in.
  - Outputs: 4-bit sum, carry-out, and the internal carry into bit 3 (needed for ovf).
- The controller holds the FSM, counter, operand registers, carry register and result registers.

Test Plan:
All scenarios use WIDTH = 16.
1. a=0x1234, b=0x4321, cin=0, res_ready=1 -> sum=0x5555, cout=0, ovf=0; res_valid rises 4 edges after accept and is high for 1 cycle.
2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry propagates through every nibble pass).
3. a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; and a=0x0000, b=0x0000, cin=1 -> sum=0x0001.
4. Hold res_ready=0 for 6 cycles after res_valid while start_valid=1 with new operands -> sum/res_valid stable, start_ready=0, busy=1, no accept. Then pulse res_ready -> IDLE, and the new operands are accepted on the following edge.
5. Assert rst_n=0 mid-RUN (idx=2) -> all outputs reset immediately without waiting for a clock edge. After release: start_ready=1, no res_valid, and the next add of 0x0F0F+0x00F1 gives 0x1000 correctly.
6. With CLA_SEQ_SUB_EN defined: op_sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0; and a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
